// File: rtl/cordic_pkg.sv
// Shared constants and the result-entry type for the CORDIC scheduler and its result FIFO.
package cordic_pkg;

  localparam int REQ_NUMBER            = 4;
  localparam int UNSIGNED_INPUT_WIDTH  = 16;
  localparam int UNSIGNED_OUTPUT_WIDTH = 16;
  localparam int ITERATION_NUMBER      = 6;
  localparam int PIPELINE_LATENCY      = ITERATION_NUMBER + 2;
  localparam int FIFO_DEPTH            = 8;
  localparam int ID_W                  = $clog2(REQ_NUMBER);

  typedef struct packed {
    logic [ID_W-1:0]                  id;
    logic [UNSIGNED_OUTPUT_WIDTH-1:0] mag;
    logic [UNSIGNED_OUTPUT_WIDTH-1:0] ang;
  } rsp_entry_t;

endpackage

// File: rtl/sched_result_fifo.sv
// Show-ahead synchronous FIFO of result entries; the head reads as zero while empty.
module sched_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  rsp_entry_t wr_data_i,
  input  logic       rd_en_i,
  output rsp_entry_t rd_data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_ok, rd_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign rd_ok     = rd_en_i && !empty_o;
  // A write into a full FIFO is accepted only when the head is leaving in the same cycle.
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
    if (!wr_ok && rd_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_i && full_o && !rd_en_i));

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin, credit-admitted sharing of one fixed-latency CORDIC pipeline among several requesters.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int REQ_NUMBER            = cordic_pkg::REQ_NUMBER,
  parameter int UNSIGNED_INPUT_WIDTH  = cordic_pkg::UNSIGNED_INPUT_WIDTH,
  parameter int UNSIGNED_OUTPUT_WIDTH = cordic_pkg::UNSIGNED_OUTPUT_WIDTH,
  parameter int ITERATION_NUMBER      = cordic_pkg::ITERATION_NUMBER,
  parameter int PIPELINE_LATENCY      = ITERATION_NUMBER + 2,
  parameter int FIFO_DEPTH            = cordic_pkg::FIFO_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [REQ_NUMBER-1:0]                    req_valid,
  input  logic [REQ_NUMBER*UNSIGNED_INPUT_WIDTH-1:0] req_x,
  input  logic [REQ_NUMBER*UNSIGNED_INPUT_WIDTH-1:0] req_y,
  output logic [REQ_NUMBER-1:0]                    req_ready,
  output logic                                     pipe_in_valid,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]          pipe_in_x,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]          pipe_in_y,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0]         pipe_mag,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0]         pipe_ang,
  output logic                                     rsp_valid,
  output logic [$clog2(REQ_NUMBER)-1:0]            rsp_id,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0]         rsp_mag,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0]         rsp_ang,
  input  logic                                     rsp_ready,
  output logic                                     busy
);

  localparam int IDW   = $clog2(REQ_NUMBER);
  localparam int IW    = UNSIGNED_INPUT_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int L     = PIPELINE_LATENCY;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never waits on a transfer, and valid holding low is always legal.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx, cand;
  logic [IDW:0]     sum;
  logic [IW-1:0]    gnt_x, gnt_y;
  logic             admit, accept, pop;

  logic             pipe_vld_q;
  logic [IW-1:0]    pipe_x_q, pipe_y_q;
  logic [IDW-1:0]   issue_id_q;
  logic [L-1:0]     tag_vld_q;
  logic [IDW-1:0]   tag_id_q [L];

  rsp_entry_t       fifo_wr_data, fifo_head;
  logic             fifo_empty, fifo_full;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < REQ_NUMBER; i++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(REQ_NUMBER)) sum = sum - (IDW+1)'(REQ_NUMBER);
      cand = sum[IDW-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign admit  = (cnt_q < CNT_W'(FIFO_DEPTH));
  assign accept = rst_n && admit && gnt_found;
  assign pop    = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    gnt_x     = '0;
    gnt_y     = '0;
    for (int i = 0; i < REQ_NUMBER; i++) begin
      if (gnt_idx == IDW'(i)) begin
        req_ready[i] = accept;
        gnt_x        = req_x[i*IW +: IW];
        gnt_y        = req_y[i*IW +: IW];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_idx == IDW'(REQ_NUMBER - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      pipe_vld_q <= 1'b0;
      pipe_x_q   <= '0;
      pipe_y_q   <= '0;
      issue_id_q <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < L; k++) tag_id_q[k] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      pipe_vld_q <= accept;
      if (accept) begin
        pipe_x_q   <= gnt_x;
        pipe_y_q   <= gnt_y;
        issue_id_q <= gnt_idx;
      end
      // The tag line mirrors the pipeline so its last stage lines up with pipe_mag/pipe_ang.
      tag_vld_q   <= {tag_vld_q[L-2:0], pipe_vld_q};
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < L; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  assign pipe_in_valid = pipe_vld_q;
  assign pipe_in_x     = pipe_x_q;
  assign pipe_in_y     = pipe_y_q;

  assign fifo_wr_data.id  = tag_id_q[L-1];
  assign fifo_wr_data.mag = pipe_mag;
  assign fifo_wr_data.ang = pipe_ang;

  sched_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (tag_vld_q[L-1]),
    .wr_data_i(fifo_wr_data),
    .rd_en_i  (pop),
    .rd_data_o(fifo_head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_head.id;
  assign rsp_mag   = fifo_head.mag;
  assign rsp_ang   = fifo_head.ang;
  assign busy      = (cnt_q != '0);

  // Credits make a FIFO overflow unreachable; the full flag only feeds the FIFO's own check.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
